iob_vex_bus_arbiter: RTL and testbench
======================================

Name: iob_vex_bus_arbiter

Overview:
- Shares one IOb native memory port between the VexRiscv wrapper's instruction bus (read-only) and data bus (read/write).
- Sits between the core wrapper and the single internal-memory or external-memory port.
- Arbitrates requests, holds a grant until the slave accepts the request, and tracks outstanding reads so each rvalid/rdata is routed back to the requester that issued it.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- MAX_RD, 2, maximum outstanding accepted reads; range 1..8.
- RR, 0, arbitration policy: 0 = fixed priority to dbus; 1 = round-robin.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ibus_valid  in  1  instruction request valid
- ibus_addr  in  ADDR_W  instruction address
- ibus_ready  out  1  instruction request accepted
- ibus_rvalid  out  1  instruction read data valid
- ibus_rdata  out  DATA_W  instruction read data
- dbus_valid  in  1  data request valid
- dbus_addr  in  ADDR_W  data address
- dbus_wdata  in  DATA_W  write data
- dbus_wstrb  in  DATA_W/8  write strobe; 0 means read
- dbus_ready  out  1  data request accepted
- dbus_rvalid  out  1  data read data valid
- dbus_rdata  out  DATA_W  data read data
- m_valid  out  1  shared port request valid
- m_addr  out  ADDR_W  shared port address
- m_wdata  out  DATA_W  shared port write data
- m_wstrb  out  DATA_W/8  shared port strobe
- m_ready  in  1  shared port request accepted
- m_rvalid  in  1  shared port read data valid
- m_rdata  in  DATA_W  shared port read data
- err  out  1  sticky flag: response received with no outstanding read

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset state: lock=0, owner=ibus, rr_last=dbus, read FIFO empty (count=0), err=0.
- Output values during reset and idle: all outputs 0.
- Handshake: a request transfers in the cycle where m_valid & m_ready. Requesters hold valid and payload stable until their ready is asserted.
- Arbitration (combinational) when lock=0:
  - Only one requester valid: that requester is selected.
  - Both valid, RR=0: dbus is selected.
  - Both valid, RR=1: the requester not equal to rr_last is selected.
  - rr_last updates to the requester of each accepted transfer.
- Lock:
  - In any cycle with m_valid & ~m_ready: lock<=1 and owner<=selected requester.
  - While lock=1, the selection is forced to owner.
  - lock clears in the cycle the request is accepted.
  - The slave therefore never sees a payload change while valid is pending.
- Mux:
  - m_addr, m_wdata and m_wstrb come from the selected requester.
  - For ibus: m_wdata=0 and m_wstrb=0.
  - m_valid = selected valid & ~fifo_full.
- Ready: the selected requester's ready = m_valid & m_ready. The other requester's ready = 0. Ready is combinational (zero added latency).
- Read tracking:
  - An accepted transfer with m_wstrb==0 pushes a 1-bit ID (0=ibus, 1=dbus) into a FIFO of depth MAX_RD.
  - Writes push nothing.
- Response routing:
  - m_rvalid pops the FIFO head.
  - If head=ibus: ibus_rvalid=1 and ibus_rdata=m_rdata.
  - If head=dbus: dbus_rvalid=1 and dbus_rdata=m_rdata.
  - Non-selected rdata outputs are driven 0.
- Full: when count==MAX_RD, m_valid=0 and both readies=0. The FIFO is not full in the same cycle as a pop, so a push and a pop at count==MAX_RD are allowed.
- Simultaneous push and pop: both take effect and count is unchanged. The popped ID is the old head.
- Empty: m_rvalid with count==0 is dropped, no rvalid is produced, and err<=1. err stays set until reset.
- Slave contract: read response latency ≥1 cycle after acceptance.
- Reset mid-transaction: lock and FIFO clear. Any later m_rvalid for a request accepted before reset is dropped and sets err.
- Implementation: circular FIFO with wrap-around read/write pointers of width clog2(MAX_RD) (minimum 1) and a count register.

Test Plan:
- Reset, then ibus read at addr 0x100 and m_ready=1 → m_addr=0x100, m_wstrb=0, ibus_ready=1. Next-cycle m_rvalid with m_rdata=0xDEADBEEF → ibus_rvalid=1, ibus_rdata=0xDEADBEEF, dbus_rvalid=0.
- RR=0, ibus (0x200) and dbus (0x300) valid in the same cycle, m_ready=1 → dbus granted first, ibus granted in the next cycle. Responses routed in order dbus then ibus.
- dbus write of 0x12345678 to 0x40 with wstrb=0xF and m_ready=0 for 3 cycles, ibus valid meanwhile → m_addr stays 0x40 for all cycles and ibus_ready=0. Accepted on the 4th cycle; count stays 0.
- MAX_RD=2, slave accepts 2 ibus reads and withholds rvalid → m_valid=0 and ready=0 on the third request. One rvalid pops the FIFO and the third request is accepted in that same cycle.
- RR=1, both requesters continuously valid, m_ready=1 → grants alternate dbus, ibus, dbus, ibus… and the rdata routing matches the issue order.
- m_rvalid pulse with the FIFO empty → no requester rvalid and err=1. err stays 1 until rst=1 for one cycle, which also clears pending lock and count.

Source files
------------

// File: rtl/iob_vex_bus_arbiter.sv
// iob_vex_bus_arbiter
//   Shares one IOb native memory port between the VexRiscv instruction bus
//   (read-only) and data bus (read/write). Arbitrates, holds the grant while
//   the slave stalls, and remembers which requester issued each accepted read
//   so every response is routed back to its owner.
//
// Handshake: a request transfers in the cycle where m_valid & m_ready are both
//   high; the winning requester sees its ready in that same cycle
//   (combinational). Requesters hold valid and payload until ready. Read
//   responses (m_rvalid/m_rdata) carry no ready and arrive in issue order, at
//   least one cycle after acceptance.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ibus_valid/addr/ready         instruction request channel
//   ibus_rvalid/rdata             instruction read response
//   dbus_valid/addr/wdata/wstrb   data request channel (wstrb==0 -> read)
//   dbus_ready                    data request accepted
//   dbus_rvalid/rdata             data read response
//   m_valid/addr/wdata/wstrb      shared request to the memory slave
//   m_ready                       slave accepted the request
//   m_rvalid/rdata                slave read response
//   err                           sticky: response with no outstanding read
module iob_vex_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_RD = 2,
  parameter int RR     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ibus_valid,
  input  logic [ADDR_W-1:0]     ibus_addr,
  output logic                  ibus_ready,
  output logic                  ibus_rvalid,
  output logic [DATA_W-1:0]     ibus_rdata,
  input  logic                  dbus_valid,
  input  logic [ADDR_W-1:0]     dbus_addr,
  input  logic [DATA_W-1:0]     dbus_wdata,
  input  logic [DATA_W/8-1:0]   dbus_wstrb,
  output logic                  dbus_ready,
  output logic                  dbus_rvalid,
  output logic [DATA_W-1:0]     dbus_rdata,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_ready,
  input  logic                  m_rvalid,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic                  err
);

  localparam int PTR_W = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
  localparam int CNT_W = $clog2(MAX_RD + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_RD - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_RD);
  localparam logic SEL_IBUS = 1'b0;
  localparam logic SEL_DBUS = 1'b1;

  logic                   lock;
  logic                   owner;
  logic                   rr_last;
  logic [(1<<PTR_W)-1:0]  id_mem;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   err_q;

  logic sel;
  logic sel_valid;
  logic active;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic accept;
  logic head;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Grant selection; a stalled request keeps its owner so the slave never
  // sees the payload change under a pending valid.
  always_comb begin
    sel = SEL_IBUS;
    if (lock) begin
      sel = owner;
    end else if (ibus_valid && dbus_valid) begin
      if (RR != 0) sel = ~rr_last;
      else         sel = SEL_DBUS;
    end else if (dbus_valid) begin
      sel = SEL_DBUS;
    end
  end

  assign sel_valid  = sel ? dbus_valid : ibus_valid;
  assign active     = sel_valid & ~rst;
  assign fifo_empty = (count == '0);
  assign pop        = m_rvalid & ~fifo_empty & ~rst;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign fifo_full  = (count == CNT_FULL) & ~pop;
  assign m_valid    = active & ~fifo_full;
  assign accept     = m_valid & m_ready;

  // Payload is zeroed when nothing is requested so the idle port is quiet.
  assign m_addr  = active ? (sel ? dbus_addr : ibus_addr) : '0;
  assign m_wdata = (active && sel) ? dbus_wdata : '0;
  assign m_wstrb = (active && sel) ? dbus_wstrb : '0;

  assign ibus_ready = accept & ~sel;
  assign dbus_ready = accept & sel;

  assign push = accept & (m_wstrb == '0);
  assign head = id_mem[rd_ptr];

  assign ibus_rvalid = pop & ~head;
  assign dbus_rvalid = pop & head;
  assign ibus_rdata  = ibus_rvalid ? m_rdata : '0;
  assign dbus_rdata  = dbus_rvalid ? m_rdata : '0;
  assign err         = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock    <= 1'b0;
      owner   <= SEL_IBUS;
      rr_last <= SEL_DBUS;
      id_mem  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (m_valid && !m_ready) begin
        lock  <= 1'b1;
        owner <= sel;
      end else if (accept) begin
        lock  <= 1'b0;
      end
      if (accept) rr_last <= sel;
      if (push) begin
        id_mem[wr_ptr] <= sel;
        wr_ptr         <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A response with nothing outstanding is dropped and flagged.
      if (m_rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iob_vex_bus_arbiter.sv
module tb_iob_vex_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- fixed-priority DUT (RR=0) ----------------
  logic        ibus_valid, ibus_ready, ibus_rvalid;
  logic [31:0] ibus_addr, ibus_rdata;
  logic        dbus_valid, dbus_ready, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_wstrb;
  logic        m_valid, m_ready, m_rvalid, err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  iob_vex_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_RD(2), .RR(0)) dut (
    .clk(clk), .rst(rst),
    .ibus_valid(ibus_valid), .ibus_addr(ibus_addr), .ibus_ready(ibus_ready),
    .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
    .dbus_valid(dbus_valid), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_wstrb(dbus_wstrb), .dbus_ready(dbus_ready),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err)
  );

  // ---------------- round-robin DUT (RR=1) ----------------
  logic        r_ibus_valid, r_ibus_ready, r_ibus_rvalid;
  logic [31:0] r_ibus_addr, r_ibus_rdata;
  logic        r_dbus_valid, r_dbus_ready, r_dbus_rvalid;
  logic [31:0] r_dbus_addr, r_dbus_wdata, r_dbus_rdata;
  logic [3:0]  r_dbus_wstrb;
  logic        r_m_valid, r_m_ready, r_m_rvalid, r_err;
  logic [31:0] r_m_addr, r_m_wdata, r_m_rdata;
  logic [3:0]  r_m_wstrb;

  iob_vex_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_RD(2), .RR(1)) dut_rr (
    .clk(clk), .rst(rst),
    .ibus_valid(r_ibus_valid), .ibus_addr(r_ibus_addr), .ibus_ready(r_ibus_ready),
    .ibus_rvalid(r_ibus_rvalid), .ibus_rdata(r_ibus_rdata),
    .dbus_valid(r_dbus_valid), .dbus_addr(r_dbus_addr), .dbus_wdata(r_dbus_wdata),
    .dbus_wstrb(r_dbus_wstrb), .dbus_ready(r_dbus_ready),
    .dbus_rvalid(r_dbus_rvalid), .dbus_rdata(r_dbus_rdata),
    .m_valid(r_m_valid), .m_addr(r_m_addr), .m_wdata(r_m_wdata), .m_wstrb(r_m_wstrb),
    .m_ready(r_m_ready), .m_rvalid(r_m_rvalid), .m_rdata(r_m_rdata), .err(r_err)
  );

  // ---------------- scoreboard ----------------
  // Entry = {requester id (0=ibus, 1=dbus), read data the slave will return}
  logic [32:0] exp_q[$];
  logic [32:0] exp_rq[$];
  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    ibus_valid = 1'b0; ibus_addr = '0;
    dbus_valid = 1'b0; dbus_addr = '0; dbus_wdata = '0; dbus_wstrb = '0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    r_ibus_valid = 1'b0; r_ibus_addr = '0;
    r_dbus_valid = 1'b0; r_dbus_addr = '0; r_dbus_wdata = '0; r_dbus_wstrb = '0;
    r_m_ready = 1'b0; r_m_rvalid = 1'b0; r_m_rdata = '0;
  endtask

  // Slave returns the oldest expected read; routing is compared against the
  // requester recorded when that read was accepted. Does not advance time
  // past the current cycle.
  task automatic sb_respond();
    logic [32:0] e;
    logic [31:0] exp_i, exp_d;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow: no expected read, got response request");
      m_rvalid = 1'b0;
    end else begin
      e = exp_q.pop_front();
      m_rvalid = 1'b1;
      m_rdata  = e[31:0];
      #1;
      exp_i = e[32] ? 32'h0 : e[31:0];
      exp_d = e[32] ? e[31:0] : 32'h0;
      if ({ibus_rvalid, dbus_rvalid, ibus_rdata, dbus_rdata} !== {~e[32], e[32], exp_i, exp_d}) begin
        errors++;
        $display("FAIL resp_route: got iv=%b dv=%b ir=%h dr=%h, want iv=%b dv=%b ir=%h dr=%h",
                 ibus_rvalid, dbus_rvalid, ibus_rdata, dbus_rdata, ~e[32], e[32], exp_i, exp_d);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    ibus_valid = 1'b1; ibus_addr = 32'h55;
    dbus_valid = 1'b1; dbus_addr = 32'h66; dbus_wstrb = 4'hF; dbus_wdata = 32'h1;
    m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h77;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({m_valid, m_addr, m_wdata, m_wstrb, ibus_ready, dbus_ready, ibus_rvalid, dbus_rvalid,
         ibus_rdata, dbus_rdata, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: mv=%b ma=%h mw=%h ms=%h ir=%b dr=%b iv=%b dv=%b err=%b, want all 0",
               m_valid, m_addr, m_wdata, m_wstrb, ibus_ready, dbus_ready, ibus_rvalid, dbus_rvalid, err);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_addr, m_wstrb, err, r_m_valid, r_err} !== '0) begin
      errors++;
      $display("FAIL idle_outputs: mv=%b ma=%h ms=%h err=%b rmv=%b rerr=%b, want all 0",
               m_valid, m_addr, m_wstrb, err, r_m_valid, r_err);
    end
  endtask

  task automatic test_ibus_read();
    @(negedge clk);
    ibus_valid = 1'b1; ibus_addr = 32'h100; m_ready = 1'b1;
    #1;
    checks++;
    if ({m_valid, m_addr, m_wstrb, ibus_ready, dbus_ready} !== {1'b1, 32'h100, 4'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ibus_req: mv=%b ma=%h ms=%h ir=%b dr=%b, want 1 100 0 1 0",
               m_valid, m_addr, m_wstrb, ibus_ready, dbus_ready);
    end
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    @(negedge clk);
    ibus_valid = 1'b0; m_ready = 1'b0;
    sb_respond();
    @(negedge clk);
    m_rvalid = 1'b0;
  endtask

  task automatic test_fixed_priority();
    logic [31:0] d0, d1;
    d0 = $urandom_range(32'h0, 32'h7FFF_FFFF);
    d1 = $urandom_range(32'h0, 32'h7FFF_FFFF);
    @(negedge clk);
    ibus_valid = 1'b1; ibus_addr = 32'h200;
    dbus_valid = 1'b1; dbus_addr = 32'h300; dbus_wstrb = 4'h0;
    m_ready = 1'b1;
    #1;
    checks++;
    if ({m_addr, dbus_ready, ibus_ready} !== {32'h300, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL prio_first: ma=%h dr=%b ir=%b, want 300 1 0", m_addr, dbus_ready, ibus_ready);
    end
    exp_q.push_back({1'b1, d0});
    @(negedge clk);
    dbus_valid = 1'b0;
    #1;
    checks++;
    if ({m_addr, dbus_ready, ibus_ready} !== {32'h200, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL prio_second: ma=%h dr=%b ir=%b, want 200 0 1", m_addr, dbus_ready, ibus_ready);
    end
    exp_q.push_back({1'b0, d1});
    @(negedge clk);
    ibus_valid = 1'b0; m_ready = 1'b0;
    sb_respond();
    @(negedge clk);
    sb_respond();
    @(negedge clk);
    m_rvalid = 1'b0;
  endtask

  task automatic test_lock_write();
    @(negedge clk);
    dbus_valid = 1'b1; dbus_addr = 32'h40; dbus_wdata = 32'h12345678; dbus_wstrb = 4'hF;
    m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        @(negedge clk);
        ibus_valid = 1'b1; ibus_addr = 32'h240;
      end
      #1;
      checks++;
      if ({m_valid, m_addr, m_wdata, m_wstrb, ibus_ready, dbus_ready} !==
          {1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL write_stall c%0d: mv=%b ma=%h mw=%h ms=%h ir=%b dr=%b, want 1 40 12345678 f 0 0",
                 c, m_valid, m_addr, m_wdata, m_wstrb, ibus_ready, dbus_ready);
      end
    end
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    checks++;
    if ({m_addr, dbus_ready, ibus_ready} !== {32'h40, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL write_accept: ma=%h dr=%b ir=%b, want 40 1 0", m_addr, dbus_ready, ibus_ready);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // ibus stalls first; a later dbus request must not steal the locked grant.
  task automatic test_lock_hold();
    logic [31:0] d0, d1;
    d0 = $urandom_range(32'h1000, 32'hFFFF);
    d1 = $urandom_range(32'h1000, 32'hFFFF);
    @(negedge clk);
    ibus_valid = 1'b1; ibus_addr = 32'h500; m_ready = 1'b0;
    @(negedge clk);
    dbus_valid = 1'b1; dbus_addr = 32'h600; dbus_wstrb = 4'h0;
    #1;
    checks++;
    if ({m_valid, m_addr, ibus_ready, dbus_ready} !== {1'b1, 32'h500, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL lock_hold: mv=%b ma=%h ir=%b dr=%b, want 1 500 0 0",
               m_valid, m_addr, ibus_ready, dbus_ready);
    end
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    checks++;
    if ({m_addr, ibus_ready, dbus_ready} !== {32'h500, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lock_accept: ma=%h ir=%b dr=%b, want 500 1 0", m_addr, ibus_ready, dbus_ready);
    end
    exp_q.push_back({1'b0, d0});
    @(negedge clk);
    ibus_valid = 1'b0;
    #1;
    checks++;
    if ({m_addr, ibus_ready, dbus_ready} !== {32'h600, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL lock_next: ma=%h ir=%b dr=%b, want 600 0 1", m_addr, ibus_ready, dbus_ready);
    end
    exp_q.push_back({1'b1, d1});
    @(negedge clk);
    dbus_valid = 1'b0; m_ready = 1'b0;
    sb_respond();
    @(negedge clk);
    sb_respond();
    @(negedge clk);
    m_rvalid = 1'b0;
  endtask

  task automatic test_fifo_full();
    @(negedge clk);
    ibus_valid = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk);
      ibus_addr = 32'h700 + 32'(k * 4);
      #1;
      checks++;
      if (ibus_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_fill%0d: ir=%b, want 1", k, ibus_ready);
      end
      exp_q.push_back({1'b0, 32'hA000_0000 + 32'(k)});
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ibus_addr = 32'h708;
      #1;
      checks++;
      if ({m_valid, ibus_ready, dbus_ready} !== 3'b000) begin
        errors++;
        $display("FAIL full_block%0d: mv=%b ir=%b dr=%b, want 0 0 0", k, m_valid, ibus_ready, dbus_ready);
      end
    end
    @(negedge clk);
    sb_respond();
    checks++;
    if ({m_valid, m_addr, ibus_ready} !== {1'b1, 32'h708, 1'b1}) begin
      errors++;
      $display("FAIL full_pop_push: mv=%b ma=%h ir=%b, want 1 708 1", m_valid, m_addr, ibus_ready);
    end
    exp_q.push_back({1'b0, 32'hA000_0002});
    @(negedge clk);
    ibus_valid = 1'b0; m_ready = 1'b0;
    sb_respond();
    @(negedge clk);
    sb_respond();
    @(negedge clk);
    m_rvalid = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [31:0] ia, da;
    logic [32:0] e;
    logic        g;
    ia = 32'h10; da = 32'h80;
    @(negedge clk);
    r_ibus_valid = 1'b1; r_ibus_addr = ia; r_m_ready = 1'b1;
    #1;
    checks++;
    if ({r_ibus_ready, r_dbus_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rr_seed: ir=%b dr=%b, want 1 0", r_ibus_ready, r_dbus_ready);
    end
    exp_rq.push_back({1'b0, 32'($urandom_range(0, 32'hFFFF))});
    ia = ia + 4;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      r_ibus_addr = ia;
      r_dbus_valid = 1'b1; r_dbus_addr = da; r_dbus_wstrb = 4'h0;
      e = exp_rq.pop_front();
      r_m_rvalid = 1'b1; r_m_rdata = e[31:0];
      #1;
      checks++;
      if ({r_ibus_rvalid, r_dbus_rvalid, r_ibus_rdata, r_dbus_rdata} !==
          {~e[32], e[32], (e[32] ? 32'h0 : e[31:0]), (e[32] ? e[31:0] : 32'h0)}) begin
        errors++;
        $display("FAIL rr_resp%0d: iv=%b dv=%b ir=%h dr=%h, want id=%b data=%h",
                 k, r_ibus_rvalid, r_dbus_rvalid, r_ibus_rdata, r_dbus_rdata, e[32], e[31:0]);
      end
      g = (k % 2 == 0);
      checks++;
      if ({r_m_addr, r_dbus_ready, r_ibus_ready} !== {(g ? da : ia), g, ~g}) begin
        errors++;
        $display("FAIL rr_grant%0d: ma=%h dr=%b ir=%b, want %h %b %b",
                 k, r_m_addr, r_dbus_ready, r_ibus_ready, (g ? da : ia), g, ~g);
      end
      exp_rq.push_back({g, 32'($urandom_range(0, 32'hFFFF))});
      if (g) da = da + 4;
      else   ia = ia + 4;
    end
    @(negedge clk);
    r_ibus_valid = 1'b0; r_dbus_valid = 1'b0; r_m_ready = 1'b0;
    e = exp_rq.pop_front();
    r_m_rvalid = 1'b1; r_m_rdata = e[31:0];
    #1;
    checks++;
    if ({r_ibus_rvalid, r_dbus_rvalid} !== {~e[32], e[32]}) begin
      errors++;
      $display("FAIL rr_last_resp: iv=%b dv=%b, want id=%b", r_ibus_rvalid, r_dbus_rvalid, e[32]);
    end
    @(negedge clk);
    r_m_rvalid = 1'b0;
  endtask

  task automatic test_err_and_reset();
    @(negedge clk);
    m_rvalid = 1'b1; m_rdata = 32'hBAD0BAD0;
    #1;
    checks++;
    if ({ibus_rvalid, dbus_rvalid, err} !== 3'b000) begin
      errors++;
      $display("FAIL empty_resp: iv=%b dv=%b err=%b, want 0 0 0", ibus_rvalid, dbus_rvalid, err);
    end
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: err=%b, want 1", err);
    end
    // Leave one read outstanding and a stalled ibus request locked.
    @(negedge clk);
    ibus_valid = 1'b1; ibus_addr = 32'h900; m_ready = 1'b1;
    @(negedge clk);
    ibus_addr = 32'h904; m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1; ibus_valid = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b, want 1", err);
    end
    @(negedge clk);
    rst = 1'b0;
    dbus_valid = 1'b1; dbus_addr = 32'hA00; dbus_wdata = 32'h5; dbus_wstrb = 4'hF; m_ready = 1'b1;
    #1;
    checks++;
    if ({err, m_valid, m_addr, dbus_ready} !== {1'b0, 1'b1, 32'hA00, 1'b1}) begin
      errors++;
      $display("FAIL post_reset: err=%b mv=%b ma=%h dr=%b, want 0 1 a00 1",
               err, m_valid, m_addr, dbus_ready);
    end
    @(negedge clk);
    dbus_valid = 1'b0; m_ready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h1234;
    #1;
    checks++;
    if ({ibus_rvalid, dbus_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL stale_resp: iv=%b dv=%b, want 0 0", ibus_rvalid, dbus_rvalid);
    end
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL stale_err: err=%b, want 1", err);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_ibus_read();
    test_fixed_priority();
    test_lock_write();
    test_lock_hold();
    test_fifo_full();
    test_round_robin();
    test_err_and_reset();
    checks++;
    if (exp_q.size() + exp_rq.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected reads never returned, want 0",
               exp_q.size() + exp_rq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
